// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - cpu32 general-purpose register file, two async read ports, one sync write port
module cpu_regfile #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter bit          ZERO_REG  = 1'b1,
   parameter bit          WR_BYPASS = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr_en;

   // Writes to the hard-wired zero register are dropped here so it never holds a value.
   assign wr_en = we_i && !(ZERO_REG && (waddr_i == '0));

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr_i] = wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reset also masks the bypass path, so outputs stay 0 for the whole reset window.
   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      if (rst_i || (ZERO_REG && (raddr1_i == '0))) begin
         rdata1_o = '0;
      end else if (WR_BYPASS && we_i && (raddr1_i == waddr_i)) begin
         rdata1_o = wdata_i;
      end
   end

   always_comb begin
      rdata2_o = regs_q[raddr2_i];
      if (rst_i || (ZERO_REG && (raddr2_i == '0))) begin
         rdata2_o = '0;
      end else if (WR_BYPASS && we_i && (raddr2_i == waddr_i)) begin
         rdata2_o = wdata_i;
      end
   end

endmodule

// File: tb/tb_cpu_regfile.sv
// tb/tb_cpu_regfile.sv - directed table-driven bench for cpu_regfile
module tb_cpu_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1, rdata2;
   logic [31:0] byp_rdata1, byp_rdata2;
   logic [31:0] nz_rdata1, nz_rdata2;

   int checks = 0;
   int errors = 0;

   cpu_regfile u_dut (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr1_i(raddr1), .raddr2_i(raddr2), .rdata1_o(rdata1), .rdata2_o(rdata2)
   );

   cpu_regfile #(.ZERO_REG(1'b1), .WR_BYPASS(1'b1)) u_byp (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr1_i(raddr1), .raddr2_i(raddr2), .rdata1_o(byp_rdata1), .rdata2_o(byp_rdata2)
   );

   cpu_regfile #(.ZERO_REG(1'b0), .WR_BYPASS(1'b1)) u_nz (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr1_i(raddr1), .raddr2_i(raddr2), .rdata1_o(nz_rdata1), .rdata2_o(nz_rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic        do_clk;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd0,  1'b1, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b1, 5'd10, 32'hCAFEBABE, 5'd3,  5'd10, 1'b1, 32'hDEADBEEF, 32'hCAFEBABE};
      vecs[2]  = '{1'b0, 5'd3,  32'h11112222, 5'd3,  5'd10, 1'b1, 32'hDEADBEEF, 32'hCAFEBABE};
      vecs[3]  = '{1'b0, 5'd3,  32'h11112222, 5'd10, 5'd10, 1'b0, 32'hCAFEBABE, 32'hCAFEBABE};
      vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0};
      vecs[5]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 1'b0, 32'h0,        32'h0};
      vecs[6]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[7]  = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd30, 1'b0, 32'hA5A5A5A5, 32'h0};
      vecs[8]  = '{1'b0, 5'd31, 32'h12345678, 5'd31, 5'd3,  1'b1, 32'hA5A5A5A5, 32'hDEADBEEF};
      vecs[9]  = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd2,  1'b1, 32'h00000001, 32'h0};
      vecs[10] = '{1'b0, 5'd1,  32'h00000001, 5'd2,  5'd1,  1'b0, 32'h0,        32'h00000001};

      // Reset held through an edge with a write pending: everything reads 0.
      rst = 1'b1; we = 1'b1; waddr = 5'd1; wdata = 32'hFFFF0000;
      raddr1 = 5'd0; raddr2 = 5'd1;
      @(posedge clk); #1;
      check("rst_rd1", rdata1, 32'h0);
      check("rst_rd2", rdata2, 32'h0);
      check("rst_byp_rd2", byp_rdata2, 32'h0);
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("rst_blocked_wr", rdata2, 32'h0);

      for (int i = 0; i < 11; i++) begin
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         raddr1 = vecs[i].raddr1; raddr2 = vecs[i].raddr2;
         if (vecs[i].do_clk) @(posedge clk);
         #1;
         check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      end

      // Non-zero-reg instance stored the write to address 0 from vec4.
      we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd10; #1;
      check("nz_reg0_stored", nz_rdata1, 32'hFFFFFFFF);
      check("byp_reg0_zero", byp_rdata1, 32'h0);

      // Same-cycle read of the write address, with and without bypass.
      we = 1'b1; waddr = 5'd7; wdata = 32'h77777777; raddr1 = 5'd7; raddr2 = 5'd0; #1;
      check("nobyp_old_val", rdata1, 32'h0);
      check("byp_new_val", byp_rdata1, 32'h77777777);
      check("nz_byp_rd2_old", nz_rdata2, 32'hFFFFFFFF);
      waddr = 5'd0; wdata = 32'h00000005; raddr1 = 5'd0; raddr2 = 5'd0; #1;
      check("byp_zero_reg", byp_rdata1, 32'h0);
      check("nz_byp_addr0", nz_rdata2, 32'h00000005);
      we = 1'b0;
      @(posedge clk); #1;

      // Reset asserted mid-cycle clears state before the next edge.
      raddr1 = 5'd3; raddr2 = 5'd10; #1;
      check("pre_rst_rd1", rdata1, 32'hDEADBEEF);
      rst = 1'b1; #1;
      check("midrst_rd1", rdata1, 32'h0);
      check("midrst_rd2", rdata2, 32'h0);
      raddr2 = 5'd0; #1;
      check("midrst_nz_reg0", nz_rdata2, 32'h0);

      // Write pending across reset release lands only at the first edge seeing rst low.
      we = 1'b1; waddr = 5'd3; wdata = 32'h00000009;
      @(posedge clk); #1;
      check("rst_hold_wr", rdata1, 32'h0);
      @(negedge clk);
      rst = 1'b0; #1;
      check("post_rel_pre_edge", rdata1, 32'h0);
      @(posedge clk); #1;
      check("post_rel_write", rdata1, 32'h00000009);
      we = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
